hist_eq_sequencer: RTL and testbench

//  Top-level phase controller for the histogram equalizer. On go it runs four phases in order:

---
 rtl/hist_eq_pkg.sv | 23 ++
 rtl/hist_eq_watchdog.sv | 38 +++
 rtl/hist_eq_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_hist_eq_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hist_eq_pkg.sv
// Shared types and widths for the histogram equalizer slice.
// This package holds the phase-controller state encoding and the scratchpad bus geometry.
package hist_eq_pkg;

  localparam int SCRATCH_ADDR_W = 16;
  localparam int SCRATCH_DATA_W = 128;
  localparam int BIN_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_HIST  = 3'd2,
    ST_CDF   = 3'd3,
    ST_MAP   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

  function automatic logic isEnginePhase(input state_e s);
    return (s == ST_HIST) || (s == ST_CDF) || (s == ST_MAP);
  endfunction

endpackage

// File: rtl/hist_eq_watchdog.sv
// Per-phase watchdog: load clears the count, enable advances it.
// It flags the first cycle of a phase and the last cycle allowed before timeout.
module hist_eq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clock,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic first_o,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign first_o  = (cnt_q == '0);
  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hist_eq_sequencer.sv
// Phase controller for the histogram equalizer: CLEAR, HIST, CDF, MAP per frame.
// It owns the scratchpad write port, ping-pongs the bank per frame and watchdogs each engine phase.
module hist_eq_sequencer
  import hist_eq_pkg::*;
#(
  parameter int HIST_BINS      = 256,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      go_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      err_o,
  output logic                      bank_sel_o,
  output logic                      hist_start_o,
  input  logic                      hist_done_i,
  output logic                      cdf_start_o,
  input  logic                      cdf_done_i,
  output logic                      map_start_o,
  input  logic                      map_done_i,
  input  logic                      eng_m2_we_i,
  input  logic [SCRATCH_ADDR_W-1:0] eng_m2_waddr_i,
  input  logic [SCRATCH_DATA_W-1:0] eng_m2_wdata_i,
  output logic                      m2_we_o,
  output logic [SCRATCH_ADDR_W-1:0] m2_waddr_o,
  output logic [SCRATCH_DATA_W-1:0] m2_wdata_o
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(HIST_BINS - 1);
  localparam int               PAD_W    = SCRATCH_ADDR_W - BIN_W - 1;

  state_e                    state_q, state_d;
  state_e                    nextPhase_q, nextPhase_d;
  logic [BIN_W-1:0]          clrIdx_q, clrIdx_d;
  logic                      bankSel_q, bankSel_d;
  logic                      busy_q, busy_d;
  logic                      frameDone_q, frameDone_d;
  logic                      err_q, err_d;
  logic                      histStart_q, histStart_d;
  logic                      cdfStart_q, cdfStart_d;
  logic                      mapStart_q, mapStart_d;
  logic                      m2We_q, m2We_d;
  logic [SCRATCH_ADDR_W-1:0] m2Waddr_q, m2Waddr_d;
  logic [SCRATCH_DATA_W-1:0] m2Wdata_q, m2Wdata_d;

  logic phaseActive;
  logic phaseDone;
  logic wdFirst;
  logic wdExpire;

  assign phaseActive = isEnginePhase(state_q);

  // Every engine phase is entered from CLEAR or DRAIN, so the counter is always zero on entry.
  hist_eq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .rst_n   (rst_n),
    .load_i  (!phaseActive),
    .en_i    (phaseActive),
    .first_o (wdFirst),
    .expire_o(wdExpire)
  );

  always_comb begin
    phaseDone = 1'b0;
    case (state_q)
      ST_HIST: phaseDone = hist_done_i;
      ST_CDF:  phaseDone = cdf_done_i;
      ST_MAP:  phaseDone = map_done_i;
      default: phaseDone = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    nextPhase_d = nextPhase_q;
    clrIdx_d    = clrIdx_q;
    bankSel_d   = bankSel_q;
    frameDone_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          state_d  = ST_CLEAR;
          clrIdx_d = '0;
        end
      end
      ST_CLEAR: begin
        clrIdx_d = clrIdx_q + 1'b1;
        if (clrIdx_q == LAST_BIN) begin
          state_d = ST_HIST;
        end
      end
      ST_HIST, ST_CDF, ST_MAP: begin
        // A done seen while start is just rising is stale and ignored.
        if (phaseDone && !wdFirst) begin
          state_d = ST_DRAIN;
          case (state_q)
            ST_HIST: nextPhase_d = ST_CDF;
            ST_CDF:  nextPhase_d = ST_MAP;
            default: nextPhase_d = ST_IDLE;
          endcase
        end else if (wdExpire) begin
          state_d = ST_ERROR;
        end
      end
      ST_DRAIN: begin
        state_d = nextPhase_q;
        if (nextPhase_q == ST_IDLE) begin
          frameDone_d = 1'b1;
          bankSel_d   = !bankSel_q;
        end
      end
      ST_ERROR: begin
        if (!go_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      frameDone_d = 1'b0;
      bankSel_d   = bankSel_q;
    end
  end

  // Outputs are registered and computed from the state being entered, so they line up with it.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    err_d       = (state_d == ST_ERROR);
    histStart_d = (state_d == ST_HIST);
    cdfStart_d  = (state_d == ST_CDF);
    mapStart_d  = (state_d == ST_MAP);
    m2We_d      = 1'b0;
    m2Waddr_d   = m2Waddr_q;
    m2Wdata_d   = m2Wdata_q;

    if (state_d == ST_CLEAR) begin
      m2We_d    = 1'b1;
      m2Waddr_d = {{PAD_W{1'b0}}, bankSel_d, clrIdx_d};
      m2Wdata_d = '0;
    end else if (phaseActive && (state_d != ST_IDLE) && (state_d != ST_ERROR)) begin
      // An x/z write enable falls to the else path and is treated as no write.
      if (eng_m2_we_i) begin
        m2We_d = 1'b1;
      end
      m2Waddr_d = eng_m2_waddr_i;
      m2Wdata_d = eng_m2_wdata_i;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      nextPhase_q <= ST_IDLE;
      clrIdx_q    <= '0;
      bankSel_q   <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      err_q       <= 1'b0;
      histStart_q <= 1'b0;
      cdfStart_q  <= 1'b0;
      mapStart_q  <= 1'b0;
      m2We_q      <= 1'b0;
      m2Waddr_q   <= '0;
      m2Wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      nextPhase_q <= nextPhase_d;
      clrIdx_q    <= clrIdx_d;
      bankSel_q   <= bankSel_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
      err_q       <= err_d;
      histStart_q <= histStart_d;
      cdfStart_q  <= cdfStart_d;
      mapStart_q  <= mapStart_d;
      m2We_q      <= m2We_d;
      m2Waddr_q   <= m2Waddr_d;
      m2Wdata_q   <= m2Wdata_d;
    end
  end

  assign busy_o       = busy_q;
  assign frame_done_o = frameDone_q;
  assign err_o        = err_q;
  assign bank_sel_o   = bankSel_q;
  assign hist_start_o = histStart_q;
  assign cdf_start_o  = cdfStart_q;
  assign map_start_o  = mapStart_q;
  assign m2_we_o      = m2We_q;
  assign m2_waddr_o   = m2Waddr_q;
  assign m2_wdata_o   = m2Wdata_q;

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// Bench for hist_eq_sequencer: directed frames with randomized engine latencies and bus traffic.
// Expected values come from a frame-level model of clear sweep, phase lengths and bank ping-pong.
module tb_hist_eq_sequencer;
  import hist_eq_pkg::*;

  localparam int BINS = 256;
  localparam int TMO  = 16;

  typedef enum {RUN_NORMAL, RUN_ABORT, RUN_HANG, RUN_RESET} mode_e;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         go = 1'b0;
  logic         abort = 1'b0;
  logic         histDone = 1'b0;
  logic         cdfDone = 1'b0;
  logic         mapDone = 1'b0;
  logic         engWe = 1'b0;
  logic [15:0]  engWaddr = '0;
  logic [127:0] engWdata = '0;

  logic         busy, frameDone, err, bankSel;
  logic         histStart, cdfStart, mapStart;
  logic         m2We;
  logic [15:0]  m2Waddr;
  logic [127:0] m2Wdata;

  int checks   = 0;
  int failures = 0;
  bit expBank  = 1'b0;

  hist_eq_sequencer #(
    .HIST_BINS     (BINS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .go_i          (go),
    .abort_i       (abort),
    .busy_o        (busy),
    .frame_done_o  (frameDone),
    .err_o         (err),
    .bank_sel_o    (bankSel),
    .hist_start_o  (histStart),
    .hist_done_i   (histDone),
    .cdf_start_o   (cdfStart),
    .cdf_done_i    (cdfDone),
    .map_start_o   (mapStart),
    .map_done_i    (mapDone),
    .eng_m2_we_i   (engWe),
    .eng_m2_waddr_i(engWaddr),
    .eng_m2_wdata_i(engWdata),
    .m2_we_o       (m2We),
    .m2_waddr_o    (m2Waddr),
    .m2_wdata_o    (m2Wdata)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkStarts(input string tag, input logic [2:0] exp);
    checkOutput(tag, {histStart, cdfStart, mapStart}, exp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {busy, frameDone, err, bankSel, histStart, cdfStart, mapStart, m2We}, 8'h00);
    checkOutput({tag, "_addr"}, m2Waddr, 16'h0000);
    checkOutput({tag, "_data"}, m2Wdata, 128'h0);
  endtask

  task automatic applyStimulus(input mode_e mode, input bit holdGo);
    int           lat;
    int           nCyc;
    bit           hang;
    bit           prevValid;
    bit           prevWe;
    logic [15:0]  prevAddr;
    logic [127:0] prevData;
    logic [2:0]   expStart;

    go = 1'b1;
    tick();
    if (!holdGo) go = 1'b0;

    for (int i = 0; i < BINS; i++) begin
      checkOutput("clear_we", m2We, 1'b1);
      checkOutput("clear_addr", m2Waddr, {7'b0, expBank, 8'(i)});
      checkOutput("clear_data", m2Wdata, 128'h0);
      checkStarts("clear_starts", 3'b000);
      checkOutput("clear_busy", busy, 1'b1);
      if (mode == RUN_ABORT && i == 100) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_we", m2We, 1'b0);
        checkOutput("abort_fd", frameDone, 1'b0);
        checkOutput("abort_bank", bankSel, expBank);
        tick();
        checkOutput("abort_fd2", frameDone, 1'b0);
        checkOutput("abort_idle", busy, 1'b0);
        return;
      end
      tick();
    end

    for (int p = 0; p < 3; p++) begin
      lat       = $urandom_range(0, 12);
      hang      = (mode == RUN_HANG) && (p == 1);
      nCyc      = hang ? TMO : ((lat < 1) ? 1 : lat) + 1;
      expStart  = 3'b100 >> p;
      prevValid = 1'b0;
      for (int c = 0; c < nCyc; c++) begin
        checkStarts("phase_starts", expStart);
        checkOutput("phase_busy", busy, 1'b1);
        checkOutput("phase_err", err, 1'b0);
        if (prevValid) begin
          checkOutput("eng_we", m2We, prevWe);
          checkOutput("eng_addr", m2Waddr, prevAddr);
          checkOutput("eng_data", m2Wdata, prevData);
        end
        if (mode == RUN_RESET && p == 2 && c == 2) begin
          rst_n = 1'b0;
          #1;
          checkAllZero("async_reset");
          {histDone, cdfDone, mapDone, engWe} = 4'b0000;
          @(posedge clock);
          #1;
          rst_n   = 1'b1;
          expBank = 1'b0;
          tick();
          return;
        end
        histDone = (p == 0) && (c >= lat);
        cdfDone  = (p == 1) && !hang && (c >= lat);
        mapDone  = (p == 2) && (c >= lat);
        if (p == 0 && c == 0) begin
          engWe = 1'bx;
        end else if (p == 0 && c == 1) begin
          engWe    = 1'b1;
          engWaddr = 16'h0042;
          engWdata = 128'hAAAA0005;
        end else begin
          engWe    = 1'($urandom_range(0, 1));
          engWaddr = 16'($urandom);
          engWdata = {$urandom, $urandom, $urandom, $urandom};
        end
        prevValid = 1'b1;
        prevWe    = (engWe === 1'b1);
        prevAddr  = engWaddr;
        prevData  = engWdata;
        tick();
      end
      {histDone, cdfDone, mapDone, engWe} = 4'b0000;

      if (hang) begin
        checkOutput("tmo_err", err, 1'b1);
        checkStarts("tmo_starts", 3'b000);
        checkOutput("tmo_busy", busy, 1'b1);
        checkOutput("tmo_we", m2We, 1'b0);
        go = 1'b1;
        tick();
        checkOutput("tmo_err_hold", err, 1'b1);
        go = 1'b0;
        tick();
        checkOutput("tmo_err_clr", err, 1'b0);
        checkOutput("tmo_idle", busy, 1'b0);
        checkOutput("tmo_bank", bankSel, expBank);
        return;
      end

      checkStarts("drain_starts", 3'b000);
      checkOutput("drain_busy", busy, 1'b1);
      checkOutput("drain_fd", frameDone, 1'b0);
      tick();
    end

    expBank = !expBank;
    checkOutput("fd_pulse", frameDone, 1'b1);
    checkOutput("fd_busy", busy, 1'b0);
    checkOutput("fd_bank", bankSel, expBank);
    checkStarts("fd_starts", 3'b000);
    checkOutput("fd_we", m2We, 1'b0);
    checkOutput("fd_err", err, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();
    checkOutput("idle_busy", busy, 1'b0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("idle_abort", busy, 1'b0);

    applyStimulus(RUN_NORMAL, 1'b0);
    tick();
    checkOutput("fd_single", frameDone, 1'b0);

    applyStimulus(RUN_NORMAL, 1'b1);
    applyStimulus(RUN_NORMAL, 1'b0);
    tick();

    applyStimulus(RUN_ABORT, 1'b0);
    applyStimulus(RUN_HANG, 1'b0);
    tick();

    applyStimulus(RUN_RESET, 1'b0);
    checkOutput("post_reset_bank", bankSel, 1'b0);
    applyStimulus(RUN_NORMAL, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
